// File: rtl/servo_pkg.sv
// Shared constants for the APB servo bank: register offsets, bit positions, decode helper.
package servo_pkg;

    localparam logic [7:0] AddrCtrl    = 8'h00;
    localparam logic [7:0] AddrStatus  = 8'h04;
    localparam logic [7:0] AddrPeriod  = 8'h08;
    localparam logic [7:0] AddrSlew    = 8'h0C;
    localparam logic [7:0] AddrHitCnt  = 8'h10;
    localparam logic [7:0] AddrTarget  = 8'h20;
    localparam logic [7:0] AddrCurrent = 8'h40;

    localparam int unsigned CtrlEnBit     = 0;
    localparam int unsigned CtrlIrqEnBit  = 1;
    localparam int unsigned StatusPendBit = 0;
    localparam int unsigned StatusBusyLsb = 8;

    localparam int unsigned HitCntW = 8;
    localparam int unsigned MaxNch  = 8;
    localparam int unsigned IdxW    = $clog2(MaxNch);

    typedef enum logic [2:0] {
        SelNone,
        SelCtrl,
        SelStatus,
        SelPeriod,
        SelSlew,
        SelHitCnt,
        SelTarget,
        SelCurrent
    } reg_sel_e;

    // Word-aligned decode of PADDR[7:0]; channel slots at or above nch are unmapped.
    function automatic reg_sel_e decode_addr(input logic [7:0] addr, input int unsigned nch);
        reg_sel_e sel;
        sel = SelNone;
        if (addr[1:0] == 2'b00) begin
            case (addr)
                AddrCtrl:   sel = SelCtrl;
                AddrStatus: sel = SelStatus;
                AddrPeriod: sel = SelPeriod;
                AddrSlew:   sel = SelSlew;
                AddrHitCnt: sel = SelHitCnt;
                default: begin
                    if (addr[7:5] == AddrTarget[7:5] && 32'(addr[4:2]) < nch) begin
                        sel = SelTarget;
                    end else if (addr[7:5] == AddrCurrent[7:5] && 32'(addr[4:2]) < nch) begin
                        sel = SelCurrent;
                    end
                end
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/apb_servo_bank_if.sv
// APB3 bus bundle between the fabric master and the servo bank.
interface apb_servo_bank_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/servo_channel.sv
// One servo channel: clamped target, slew-limited current width, registered PWM compare.
module servo_channel #(
    parameter int unsigned CNT_W  = 21,
    parameter int unsigned PW_MIN = 60000,
    parameter int unsigned PW_MAX = 240000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             frame_tick_i,
    input  logic [CNT_W-1:0] slew_i,
    input  logic             tgt_we_i,
    input  logic [31:0]      tgt_wdata_i,
    output logic [CNT_W-1:0] target_o,
    output logic [CNT_W-1:0] current_o,
    output logic             busy_o,
    output logic             pwm_o
);
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] current_q, current_d;
    logic [CNT_W-1:0] diff;
    logic             up;
    logic             pwm_q, pwm_d;

    // Next state: clamp on write, step toward target only at the frame boundary.
    always_comb begin
        target_d  = target_q;
        current_d = current_q;
        if (tgt_we_i) begin
            if (tgt_wdata_i < PW_MIN) begin
                target_d = CNT_W'(PW_MIN);
            end else if (tgt_wdata_i > PW_MAX) begin
                target_d = CNT_W'(PW_MAX);
            end else begin
                target_d = tgt_wdata_i[CNT_W-1:0];
            end
        end
        up   = target_q > current_q;
        diff = up ? (target_q - current_q) : (current_q - target_q);
        if (frame_tick_i) begin
            if (slew_i == '0 || diff <= slew_i) begin
                current_d = target_q;
            end else if (up) begin
                current_d = current_q + slew_i;
            end else begin
                current_d = current_q - slew_i;
            end
        end
        pwm_d = en_i && (cnt_i < current_q);
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            target_q  <= CNT_W'(PW_MIN);
            current_q <= CNT_W'(PW_MIN);
            pwm_q     <= 1'b0;
        end else begin
            target_q  <= target_d;
            current_q <= current_d;
            pwm_q     <= pwm_d;
        end
    end

    assign target_o  = target_q;
    assign current_o = current_q;
    assign busy_o    = (current_q != target_q);
    assign pwm_o     = pwm_q;
endmodule

// File: rtl/apb_servo_bank.sv
// APB3 servo bank: register decode, shared frame counter, period shadow, hit debounce, IRQ.
module apb_servo_bank
    import servo_pkg::*;
#(
    parameter int unsigned NCH            = 2,
    parameter int unsigned CNT_W          = 21,
    parameter int unsigned PERIOD_DEFAULT = 2000000,
    parameter int unsigned PW_MIN         = 60000,
    parameter int unsigned PW_MAX         = 240000,
    parameter int unsigned DEBOUNCE       = 10000000
) (
    input  logic            PCLK,
    input  logic            PRESET,
    apb_servo_bank_if.slave apb,
    output logic [NCH-1:0]  pwm_out,
    input  logic            hit_n,
    output logic            FABINT
);
    localparam int unsigned DebW = $clog2(DEBOUNCE + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    reg_sel_e            sel;
    logic [IdxW-1:0]     idx;
    logic                wr_en, rd_setup, en, frame_tick, hit;
    logic [1:0]          ctrl_q, ctrl_d;
    cnt_t                period_sh_q, period_sh_d, period_act_q, period_act_d;
    cnt_t                slew_q, slew_d, cnt_q, cnt_d;
    logic [HitCntW-1:0]  hitcnt_q, hitcnt_d;
    logic                pending_q, pending_d, fabint_q, fabint_d;
    logic [DebW-1:0]     deb_q, deb_d;
    logic [31:0]         prdata_q, prdata_d, rdata;
    cnt_t                target [NCH];
    cnt_t                current [NCH];
    logic [NCH-1:0]      busy, tgt_we;
    logic                unused_paddr;

    assign sel          = decode_addr(apb.PADDR[7:0], NCH);
    assign idx          = apb.PADDR[4:2];
    assign wr_en        = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign rd_setup     = apb.PSEL & ~apb.PENABLE;
    assign en           = ctrl_q[CtrlEnBit];
    assign frame_tick   = en && (cnt_q == period_act_q - 1'b1);
    // Fires on the DEBOUNCE-th consecutive low sample; the counter then parks one past it.
    assign hit          = ~hit_n && (deb_q == DebW'(DEBOUNCE - 1));
    assign unused_paddr = ^apb.PADDR[31:8];

    // Per-channel target write strobes.
    always_comb begin
        tgt_we = '0;
        for (int i = 0; i < NCH; i++) begin
            tgt_we[i] = wr_en && (sel == SelTarget) && (idx == IdxW'(i));
        end
    end

    // Read data mux, captured into PRDATA during the setup cycle.
    always_comb begin
        rdata = '0;
        case (sel)
            SelCtrl:   rdata[1:0] = ctrl_q;
            SelStatus: begin
                rdata[StatusPendBit] = pending_q;
                for (int i = 0; i < NCH; i++) rdata[StatusBusyLsb + i] = busy[i];
            end
            SelPeriod: rdata[CNT_W-1:0] = period_sh_q;
            SelSlew:   rdata[CNT_W-1:0] = slew_q;
            SelHitCnt: rdata[HitCntW-1:0] = hitcnt_q;
            SelTarget: begin
                for (int i = 0; i < NCH; i++) if (idx == IdxW'(i)) rdata[CNT_W-1:0] = target[i];
            end
            SelCurrent: begin
                for (int i = 0; i < NCH; i++) if (idx == IdxW'(i)) rdata[CNT_W-1:0] = current[i];
            end
            default: ;
        endcase
    end

    // Next state for bus registers, frame counter, debounce, status and interrupt.
    always_comb begin
        ctrl_d       = ctrl_q;
        period_sh_d  = period_sh_q;
        period_act_d = period_act_q;
        slew_d       = slew_q;
        cnt_d        = cnt_q;
        deb_d        = deb_q;
        pending_d    = pending_q;
        hitcnt_d     = hitcnt_q;
        if (wr_en) begin
            case (sel)
                SelCtrl:   ctrl_d = apb.PWDATA[1:0];
                SelPeriod: period_sh_d = (apb.PWDATA[CNT_W-1:0] < cnt_t'(2)) ? cnt_t'(2)
                                                                          : apb.PWDATA[CNT_W-1:0];
                SelSlew:   slew_d = apb.PWDATA[CNT_W-1:0];
                default: ;
            endcase
        end
        if (!en) begin
            cnt_d = '0;
        end else if (frame_tick) begin
            cnt_d        = '0;
            period_act_d = period_sh_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        if (hit_n) begin
            deb_d = '0;
        end else if (deb_q != DebW'(DEBOUNCE)) begin
            deb_d = deb_q + 1'b1;
        end
        // A new hit wins over a same-cycle W1C or HITCNT clear.
        if (wr_en && sel == SelStatus && apb.PWDATA[StatusPendBit]) pending_d = 1'b0;
        if (hit) pending_d = 1'b1;
        if (wr_en && sel == SelHitCnt) begin
            hitcnt_d = hit ? HitCntW'(1) : '0;
        end else if (hit && hitcnt_q != '1) begin
            hitcnt_d = hitcnt_q + 1'b1;
        end
        fabint_d = pending_q & ctrl_q[CtrlIrqEnBit];
        prdata_d = rd_setup ? rdata : prdata_q;
    end

    // Top-level state registers with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_q       <= '0;
            period_sh_q  <= cnt_t'(PERIOD_DEFAULT);
            period_act_q <= cnt_t'(PERIOD_DEFAULT);
            slew_q       <= '0;
            cnt_q        <= '0;
            deb_q        <= '0;
            pending_q    <= 1'b0;
            hitcnt_q     <= '0;
            fabint_q     <= 1'b0;
            prdata_q     <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            slew_q       <= slew_d;
            cnt_q        <= cnt_d;
            deb_q        <= deb_d;
            pending_q    <= pending_d;
            hitcnt_q     <= hitcnt_d;
            fabint_q     <= fabint_d;
            prdata_q     <= prdata_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        servo_channel #(
            .CNT_W  (CNT_W),
            .PW_MIN (PW_MIN),
            .PW_MAX (PW_MAX)
        ) u_ch (
            .clk_i        (PCLK),
            .rst_i        (PRESET),
            .en_i         (en),
            .cnt_i        (cnt_q),
            .frame_tick_i (frame_tick),
            .slew_i       (slew_q),
            .tgt_we_i     (tgt_we[g]),
            .tgt_wdata_i  (apb.PWDATA),
            .target_o     (target[g]),
            .current_o    (current[g]),
            .busy_o       (busy[g]),
            .pwm_o        (pwm_out[g])
        );
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;
    assign FABINT      = fabint_q;
endmodule

// File: tb/tb_apb_servo_bank.sv
// Self-checking bench for apb_servo_bank: register table, PWM frame timing, slew, debounce, reset.
module tb_apb_servo_bank;
    localparam int unsigned NCH = 2, CNT_W = 12, PERIOD_DEFAULT = 100;
    localparam int unsigned PW_MIN = 10, PW_MAX = 90, DEBOUNCE = 4;
    localparam int Timeout = 1000;

    localparam logic [7:0] ACtrl = 8'h00, AStat = 8'h04, APer = 8'h08, ASlew = 8'h0C;
    localparam logic [7:0] AHit = 8'h10, ATgt0 = 8'h20, ATgt1 = 8'h24, ACur0 = 8'h40;
    localparam logic [7:0] ACur1 = 8'h44;

    logic           PCLK = 1'b0;
    logic           PRESET;
    logic           hit_n;
    logic [NCH-1:0] pwm_out;
    logic           FABINT;

    apb_servo_bank_if apb();

    apb_servo_bank #(
        .NCH            (NCH),
        .CNT_W          (CNT_W),
        .PERIOD_DEFAULT (PERIOD_DEFAULT),
        .PW_MIN         (PW_MIN),
        .PW_MAX         (PW_MAX),
        .DEBOUNCE       (DEBOUNCE)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .apb     (apb),
        .pwm_out (pwm_out),
        .hit_n   (hit_n),
        .FABINT  (FABINT)
    );

    always #5 PCLK = ~PCLK;

    int unsigned cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    logic [31:0] exp_q[$];
    string       nm_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out after %0d cycles", name, Timeout);
    endtask

    function automatic void add(input bit wr, input logic [7:0] a, input logic [31:0] d,
                                input logic [31:0] e);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.exp = e;
        vecs.push_back(v);
    endfunction

    // All bus tasks are entered at a negedge and return at a negedge.
    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        apb.PADDR = {24'h0, addr}; apb.PWDATA = data; apb.PWRITE = 1'b1;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        @(negedge PCLK);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] addr, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        nm_q.push_back(name);
        apb.PADDR = {24'h0, addr}; apb.PWRITE = 1'b0;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        check(nm_q.pop_front(), apb.PRDATA, exp_q.pop_front());
        @(negedge PCLK);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    endtask

    // Wait for the next rising edge of pwm_out[0]; hi counts high samples seen beforehand.
    task automatic wait_rise(output int hi);
        logic prev;
        int   n;
        hi = 0;
        prev = pwm_out[0];
        for (n = 0; n < Timeout; n++) begin
            @(negedge PCLK);
            if (pwm_out[0] && !prev) break;
            if (pwm_out[0]) hi++;
            prev = pwm_out[0];
        end
        if (n == Timeout) timeout_fail("wait_rise");
    endtask

    // Called at a rise of pwm_out[0]; measures that frame and returns at the next rise.
    task automatic measure_frame(output int per, output int h0, output int h1);
        logic prev;
        int   n;
        per = 1; h0 = int'(pwm_out[0]); h1 = int'(pwm_out[1]);
        prev = pwm_out[0];
        for (n = 0; n < Timeout; n++) begin
            @(negedge PCLK);
            if (pwm_out[0] && !prev) break;
            per++;
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            prev = pwm_out[0];
        end
        if (n == Timeout) timeout_fail("measure_frame");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int per, h0, h1, hi;
        int unsigned t0;
        logic [31:0] exp_cur [4];

        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
        apb.PADDR = '0; apb.PWDATA = '0;
        hit_n = 1'b1;
        PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        check("reset pwm_out", 32'(pwm_out), 0);
        check("reset FABINT", 32'(FABINT), 0);
        check("reset PRDATA", apb.PRDATA, 0);
        check("PREADY", 32'(apb.PREADY), 1);
        check("PSLVERR", 32'(apb.PSLVERR), 0);
        PRESET = 1'b0;
        @(negedge PCLK);

        // Register map, reset values, clamps and unmapped slots (en stays 0 throughout).
        add(0, ACtrl, 0, 0);        add(0, AStat, 0, 0);        add(0, APer, 0, 100);
        add(0, ASlew, 0, 0);        add(0, AHit, 0, 0);         add(0, ATgt0, 0, 10);
        add(0, ATgt1, 0, 10);       add(0, ACur0, 0, 10);       add(0, ACur1, 0, 10);
        add(0, 8'h14, 0, 0);        add(0, 8'h28, 0, 0);        add(0, 8'h48, 0, 0);
        add(1, ATgt0, 200, 0);      add(0, ATgt0, 0, 90);       add(0, AStat, 0, 32'h100);
        add(1, ATgt0, 91, 0);       add(0, ATgt0, 0, 90);       add(1, ATgt0, 9, 0);
        add(0, ATgt0, 0, 10);       add(1, ATgt0, 3, 0);        add(0, ATgt0, 0, 10);
        add(0, AStat, 0, 0);        add(1, APer, 1, 0);         add(0, APer, 0, 2);
        add(1, APer, 0, 0);         add(0, APer, 0, 2);         add(1, APer, 100, 0);
        add(0, APer, 0, 100);       add(1, 8'h14, 32'hFFFF, 0); add(0, 8'h14, 0, 0);
        add(1, 8'h28, 50, 0);       add(0, 8'h28, 0, 0);        add(0, ATgt0, 0, 10);
        add(0, ATgt1, 0, 10);       add(1, ASlew, 32'hFFFFF, 0); add(0, ASlew, 0, 32'hFFF);
        add(1, ASlew, 0, 0);        add(0, ASlew, 0, 0);        add(1, AStat, 32'hFFFFFFFF, 0);
        add(0, AStat, 0, 0);        add(1, AHit, 5, 0);         add(0, AHit, 0, 0);
        add(1, ACtrl, 32'h2, 0);    add(0, ACtrl, 0, 2);        add(1, ACtrl, 0, 0);
        add(0, ACtrl, 0, 0);
        foreach (vecs[i]) begin
            if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].data);
            else apb_read(vecs[i].addr, vecs[i].exp, $sformatf("tbl[%0d] @0x%0h", i, vecs[i].addr));
        end

        // Enable: both channels 10 high out of 100.
        apb_write(ACtrl, 1);
        wait_rise(hi);
        measure_frame(per, h0, h1);
        check("en frame period", per, 100);
        check("en pwm0 high", h0, 10);
        check("en pwm1 high", h1, 10);

        // TARGET0=50 mid-frame with SLEW=0: no glitch now, full 50 next frame.
        repeat (25) @(negedge PCLK);
        apb_write(ATgt0, 50);
        wait_rise(hi);
        check("no mid-frame glitch", hi, 0);
        measure_frame(per, h0, h1);
        check("tgt0 frame period", per, 100);
        check("tgt0 pwm0 high", h0, 50);
        check("tgt0 pwm1 high", h1, 10);

        // Slew-limited ramp of channel 1.
        apb_write(ASlew, 15);
        apb_write(ATgt1, 60);
        exp_cur[0] = 25; exp_cur[1] = 40; exp_cur[2] = 55; exp_cur[3] = 60;
        for (int k = 0; k < 4; k++) begin
            wait_rise(hi);
            apb_read(ACur1, exp_cur[k], $sformatf("ramp CURRENT1 step %0d", k));
            apb_read(AStat, (k < 3) ? 32'h200 : 32'h0, $sformatf("ramp STATUS step %0d", k));
        end

        // PERIOD=50 mid-frame: this frame stays 100, following ones are 50.
        wait_rise(hi);
        t0 = cyc;
        apb_write(ASlew, 0);
        apb_write(ATgt0, 10);
        apb_write(APer, 50);
        wait_rise(hi);
        check("frame after PERIOD write", int'(cyc - t0), 100);
        measure_frame(per, h0, h1);
        check("short frame period 1", per, 50);
        check("short frame pwm0 high", h0, 10);
        check("short frame pwm1 high", h1, 50);
        measure_frame(per, h0, h1);
        check("short frame period 2", per, 50);
        apb_read(APer, 50, "PERIOD readback 50");

        // Debounce: 3 low samples do nothing.
        hit_n = 1'b0;
        repeat (3) @(negedge PCLK);
        hit_n = 1'b1;
        @(negedge PCLK);
        apb_read(AStat, 0, "3-low STATUS");
        apb_read(AHit, 0, "3-low HITCNT");

        // 4 low samples: one hit; irq_en=0 keeps FABINT low.
        hit_n = 1'b0;
        repeat (4) @(negedge PCLK);
        hit_n = 1'b1;
        @(negedge PCLK);
        check("FABINT masked", 32'(FABINT), 0);
        apb_read(AStat, 1, "hit STATUS");
        apb_read(AHit, 1, "hit HITCNT");
        apb_write(ACtrl, 3);
        @(negedge PCLK);
        check("FABINT unmasked", 32'(FABINT), 1);
        apb_write(AStat, 1);
        @(negedge PCLK);
        check("FABINT after W1C", 32'(FABINT), 0);
        apb_read(AStat, 0, "W1C STATUS");

        // Held low: exact pending/FABINT latency, single count.
        apb_write(AHit, 0);
        hit_n = 1'b0;
        repeat (4) @(negedge PCLK);
        check("FABINT one cycle after pending", 32'(FABINT), 0);
        @(negedge PCLK);
        check("FABINT after hit", 32'(FABINT), 1);
        repeat (15) @(negedge PCLK);
        apb_read(AHit, 1, "held-low HITCNT");
        hit_n = 1'b1;
        @(negedge PCLK);

        // W1C on the same edge as a new hit: pending survives.
        hit_n = 1'b0;
        repeat (2) @(negedge PCLK);
        apb_write(AStat, 1);
        hit_n = 1'b1;
        apb_read(AStat, 1, "W1C+hit STATUS");
        apb_read(AHit, 2, "W1C+hit HITCNT");

        // HITCNT clear on the same edge as a new hit: reads 1.
        hit_n = 1'b0;
        repeat (2) @(negedge PCLK);
        apb_write(AHit, 0);
        hit_n = 1'b1;
        apb_read(AHit, 1, "clear+hit HITCNT");

        // HITCNT saturates at 255.
        for (int k = 0; k < 260; k++) begin
            hit_n = 1'b0;
            repeat (4) @(negedge PCLK);
            hit_n = 1'b1;
            @(negedge PCLK);
        end
        apb_read(AHit, 255, "HITCNT saturate");

        // Reset in the middle of a ramp with en=1 and FABINT asserted.
        apb_write(ASlew, 5);
        apb_write(ATgt0, 90);
        wait_rise(hi);
        wait_rise(hi);
        apb_read(ACur0, 20, "mid-ramp CURRENT0");
        check("pre-reset pwm_out", 32'(pwm_out), 3);
        check("pre-reset FABINT", 32'(FABINT), 1);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("post-reset pwm_out", 32'(pwm_out), 0);
        check("post-reset FABINT", 32'(FABINT), 0);
        check("post-reset PRDATA", apb.PRDATA, 0);
        PRESET = 1'b0;
        @(negedge PCLK);
        apb_read(ACur0, 10, "post-reset CURRENT0");
        apb_read(ATgt0, 10, "post-reset TARGET0");
        apb_read(APer, 100, "post-reset PERIOD");
        apb_read(ACtrl, 0, "post-reset CTRL");
        apb_read(AStat, 0, "post-reset STATUS");
        apb_read(AHit, 0, "post-reset HITCNT");
        repeat (5) @(negedge PCLK);
        check("disabled pwm_out", 32'(pwm_out), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
